// File: rtl/ex_muldiv_iter_if.sv
// Purpose: request/response bundle between the execute stage and the iterative mul/div unit.
// Latency: none (wires only); timing is owned by the unit behind the slave modport.
// Backpressure: in_ready gates requests, out_ready gates results; flush travels with the request side.
interface ex_muldiv_iter_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      md_op;
  logic            inst_word;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic            busy;

  // Execute stage side: issues operations and consumes results.
  modport master (
    output flush, in_valid, md_op, inst_word, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  // Unit side.
  modport slave (
    input  flush, in_valid, md_op, inst_word, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/ex_muldiv_iter.sv
// Purpose: iterative RV64M/RV32M multiply/divide unit, one bit per cycle, flushable.
// Latency: N+2 cycles accept-to-out_valid (N=32 for word ops, else XLEN); special divides take 1 cycle.
// Backpressure: accepts only in IDLE; the result is held in DONE until out_ready, then one idle bubble.
module ex_muldiv_iter #(
  parameter int XLEN = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  ex_muldiv_iter_if.slave    io
);

  localparam int              CNT_W  = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] N_FULL = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] N_WORD = CNT_W'(32);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_busy;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_word;
  logic              r_is_mul;
  logic              r_mul_lo;
  logic              r_is_rem;
  logic              r_neg;
  logic [XLEN-1:0]   r_a;        // multiplicand or divisor magnitude
  logic [XLEN-1:0]   r_b;        // multiplier or dividend magnitude, consumed MSB-first
  logic [2*XLEN-1:0] r_acc;      // product, or {remainder, quotient}
  logic [XLEN-1:0]   r_out_data;

  // Accept-cycle decode
  logic              w_word;
  logic              w_is_mul;
  logic              w_mul_lo;
  logic              w_is_rem;
  logic              w_s1;
  logic              w_s2;
  logic              w_neg1;
  logic              w_neg2;
  logic              w_div0;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic [XLEN-1:0]   w_minneg;
  logic [XLEN-1:0]   w_spec_raw;
  logic [XLEN-1:0]   w_spec_res;

  // Iteration and fix-up
  logic [CNT_W-1:0]  w_n;
  logic              w_last;
  logic              w_bit;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic              w_qbit;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_res;
  logic [XLEN-1:0]   w_fix_res;

  // Decode the incoming op: operand extension, magnitudes, result sign and special cases.
  always_comb begin
    w_word   = io.inst_word;
    w_is_mul = ~io.md_op[2];
    // Word forms of MULH* collapse to MULW, so only the low half is ever wanted.
    w_mul_lo = w_is_mul & ((io.md_op == OP_MUL) | w_word);
    w_is_rem = io.md_op[2] & io.md_op[1];
    w_s1     = ~w_mul_lo & ((io.md_op == OP_MULH) | (io.md_op == OP_MULHSU) |
                            (io.md_op == OP_DIV)  | (io.md_op == OP_REM));
    w_s2     = ~w_mul_lo & ((io.md_op == OP_MULH) | (io.md_op == OP_DIV) |
                            (io.md_op == OP_REM));

    w_op1 = io.rs1_data;
    w_op2 = io.rs2_data;
    if (w_word) begin
      w_op1 = w_s1 ? sext32(io.rs1_data[31:0]) : XLEN'(io.rs1_data[31:0]);
      w_op2 = w_s2 ? sext32(io.rs2_data[31:0]) : XLEN'(io.rs2_data[31:0]);
    end

    w_neg1 = w_s1 & w_op1[XLEN-1];
    w_neg2 = w_s2 & w_op2[XLEN-1];
    w_mag1 = w_neg1 ? -w_op1 : w_op1;
    w_mag2 = w_neg2 ? -w_op2 : w_op2;

    w_minneg = w_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    w_div0   = io.md_op[2] & (w_op2 == '0);
    w_ovf    = io.md_op[2] & ~io.md_op[0] & (w_op1 == w_minneg) & (w_op2 == '1);
    w_special = w_div0 | w_ovf;

    if (w_div0) begin
      w_spec_raw = w_is_rem ? w_op1 : '1;
    end else begin
      w_spec_raw = w_is_rem ? '0 : w_op1;
    end
    w_spec_res = w_word ? sext32(w_spec_raw[31:0]) : w_spec_raw;
  end

  // One iteration step: MSB-first shift-add multiply or restoring divide.
  always_comb begin
    w_n      = r_word ? N_WORD : N_FULL;
    w_last   = (r_cnt == (w_n - 1'b1));
    w_bit    = r_word ? r_b[31] : r_b[XLEN-1];
    w_rem_sh = {r_acc[2*XLEN-1:XLEN], w_bit};
    w_diff   = w_rem_sh - {1'b0, r_a};
    w_qbit   = ~w_diff[XLEN];
    if (r_is_mul) begin
      w_acc_nxt = {r_acc[2*XLEN-2:0], 1'b0} + (w_bit ? {{XLEN{1'b0}}, r_a} : '0);
    end else begin
      // The shifted remainder is always below twice the divisor, so a failed
      // trial leaves its top bit clear and XLEN bits suffice to keep it.
      w_acc_nxt = {(w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                   r_acc[XLEN-2:0], w_qbit};
    end
  end

  // Sign correction and half/word selection applied in the FIX cycle.
  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    if (r_is_mul) begin
      w_res = r_mul_lo ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end else begin
      w_res = r_is_rem ? w_rem : w_quo;
    end
    w_fix_res = r_word ? sext32(w_res[31:0]) : w_res;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = (r_state == S_IDLE) & i_rst_n;
    w_out_valid = (r_state == S_DONE);
    w_busy      = (r_state != S_IDLE);
    w_accept    = io.in_valid & w_in_ready & ~io.flush;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (io.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (io.flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Datapath: latch on accept, iterate in CALC, register the result in FIX.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_word     <= 1'b0;
      r_is_mul   <= 1'b0;
      r_mul_lo   <= 1'b0;
      r_is_rem   <= 1'b0;
      r_neg      <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else if (io.flush) begin
      r_cnt      <= '0;
      r_out_data <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt    <= '0;
            r_word   <= w_word;
            r_is_mul <= w_is_mul;
            r_mul_lo <= w_mul_lo;
            r_is_rem <= w_is_rem;
            r_neg    <= w_is_rem ? w_neg1 : (w_neg1 ^ w_neg2);
            r_a      <= w_is_mul ? w_mag1 : w_mag2;
            r_b      <= w_is_mul ? w_mag2 : w_mag1;
            r_acc    <= '0;
            if (w_special) begin
              r_out_data <= w_spec_res;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_b   <= r_b << 1;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_out_data <= w_fix_res;
        end
        default: begin
        end
      endcase
    end
  end

  assign io.in_ready  = w_in_ready;
  assign io.out_valid = w_out_valid;
  assign io.busy      = w_busy;
  assign io.out_data  = r_out_data;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Purpose: directed and randomized checks of ex_muldiv_iter against an arithmetic reference.
// Latency: checks exact accept-to-result cycle counts (1, 34 or 66).
// Backpressure: exercises held out_ready, flush in CALC/DONE/IDLE and reset mid-operation.
module tb_ex_muldiv_iter;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  ex_muldiv_iter_if #(.XLEN(64)) mif ();

  ex_muldiv_iter #(.XLEN(64)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io      (mif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics computed with plain wide arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic word,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       ea, eb, p;
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic [31:0]        r32;
    logic [63:0]        r;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0];
    r = '0; r32 = '0;
    if (word) begin
      case (op)
        3'd4: if (b[31:0] == 0) r32 = '1;
              else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = a[31:0];
              else r32 = sa32 / sb32;
        3'd5: if (b[31:0] == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
        3'd6: if (b[31:0] == 0) r32 = a[31:0];
              else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = '0;
              else r32 = sa32 % sb32;
        3'd7: if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
        default: r32 = a[31:0] * b[31:0];
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      ea = (op == 3'd1 || op == 3'd2) ? {{64{a[63]}}, a} : {64'd0, a};
      eb = (op == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
      p  = ea * eb;
      case (op)
        3'd0: r = p[63:0];
        3'd1, 3'd2, 3'd3: r = p[127:64];
        3'd4: if (b == 0) r = '1;
              else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
              else r = sa / sb;
        3'd5: if (b == 0) r = '1; else r = a / b;
        3'd6: if (b == 0) r = a;
              else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
              else r = sa % sb;
        default: if (b == 0) r = a; else r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic word,
                                     input logic [63:0] a, input logic [63:0] b);
    logic bz, ovf;
    if (op < 3'd4) return word ? 34 : 66;
    bz  = word ? (b[31:0] == 0) : (b == 0);
    ovf = (op == 3'd4 || op == 3'd6) &&
          (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                : (a == 64'h8000_0000_0000_0000 && b == '1));
    return (bz || ovf) ? 1 : (word ? 34 : 66);
  endfunction

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return {$urandom, 32'h8000_0000};
      5: return {32'd0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic start_op(input logic [2:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b);
    mif.md_op = op; mif.inst_word = word; mif.rs1_data = a; mif.rs2_data = b;
    mif.in_valid = 1'b1;
    tick();
    mif.in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid is seen; bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (mif.out_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    int lat;
    check({tag, ".in_ready"}, 64'(mif.in_ready), 64'd1);
    start_op(op, word, a, b);
    wait_valid(lat);
    check({tag, ".latency"}, 64'(lat), 64'(exp_latency(op, word, a, b)));
    check({tag, ".data"}, mif.out_data, exp);
    mif.out_ready = 1'b1;
    tick();
    mif.out_ready = 1'b0;
    check({tag, ".idle"}, 64'(mif.busy), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [2:0]  op;
    logic        wd;
    logic [63:0] a, b;

    mif.flush = 1'b0; mif.in_valid = 1'b0; mif.md_op = 3'd0; mif.inst_word = 1'b0;
    mif.rs1_data = '0; mif.rs2_data = '0; mif.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst.in_ready", 64'(mif.in_ready), 64'd0);
    check("rst.out_valid", 64'(mif.out_valid), 64'd0);
    check("rst.out_data", mif.out_data, 64'd0);
    check("rst.busy", 64'(mif.busy), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready_rel", 64'(mif.in_ready), 64'd1);

    // Directed arithmetic and special cases.
    run_op("mul_m1x7",   3'd0, 1'b0, '1, 64'd7, 64'hFFFF_FFFF_FFFF_FFF9);
    run_op("mulhu_m1x7", 3'd3, 1'b0, '1, 64'd7, 64'h0000_0000_0000_0006);
    run_op("div_m7d2",   3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("rem_m7d2",   3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("divu_by0",   3'd5, 1'b0, 64'h1234, 64'd0, '1);
    run_op("remu_by0",   3'd7, 1'b0, 64'h1234, 64'd0, 64'h1234);
    run_op("div_ovf",    3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
    run_op("rem_ovf",    3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0);
    run_op("divw_ovf",   3'd4, 1'b1, 64'h0000_0001_8000_0000, '1, 64'hFFFF_FFFF_8000_0000);
    run_op("mulw_7fx2",  3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhw_asw",  3'd1, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhsu_neg", 3'd2, 1'b0, '1, 64'd3, '1);

    // Backpressure: result held while out_ready is low.
    start_op(3'd0, 1'b0, 64'd5, 64'd9);
    wait_valid(lat);
    check("bp.latency", 64'(lat), 64'd66);
    for (int i = 0; i < 10; i++) begin
      check("bp.out_valid", 64'(mif.out_valid), 64'd1);
      check("bp.out_data", mif.out_data, 64'd45);
      check("bp.in_ready", 64'(mif.in_ready), 64'd0);
      tick();
    end
    mif.out_ready = 1'b1;
    tick();
    mif.out_ready = 1'b0;
    check("bp.release_valid", 64'(mif.out_valid), 64'd0);
    check("bp.release_ready", 64'(mif.in_ready), 64'd1);

    // Flush in the 20th CALC cycle: no result may ever appear.
    start_op(3'd3, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'h0F0F_0F0F_F0F0_F0F0);
    repeat (19) tick();
    mif.flush = 1'b1;
    tick();
    mif.flush = 1'b0;
    check("flush.busy", 64'(mif.busy), 64'd0);
    check("flush.in_ready", 64'(mif.in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (mif.out_valid === 1'b1) seen++;
      tick();
    end
    check("flush.no_valid", 64'(seen), 64'd0);
    run_op("flush.mul3x5", 3'd0, 1'b0, 64'd3, 64'd5, 64'd15);

    // Request presented together with flush in IDLE is dropped.
    mif.flush = 1'b1;
    start_op(3'd0, 1'b0, 64'd3, 64'd5);
    mif.flush = 1'b0;
    check("flush_idle.busy", 64'(mif.busy), 64'd0);
    tick();
    check("flush_idle.busy2", 64'(mif.busy), 64'd0);

    // Flush beats out_ready in DONE.
    start_op(3'd5, 1'b0, 64'd100, 64'd7);
    wait_valid(lat);
    check("flush_done.data", mif.out_data, 64'd14);
    mif.flush = 1'b1; mif.out_ready = 1'b1;
    tick();
    mif.flush = 1'b0; mif.out_ready = 1'b0;
    check("flush_done.valid", 64'(mif.out_valid), 64'd0);
    check("flush_done.busy", 64'(mif.busy), 64'd0);

    // Reset mid-CALC, alone and together with flush.
    for (int k = 0; k < 2; k++) begin
      start_op(3'd4, 1'b0, 64'd1000, 64'd3);
      repeat (20) tick();
      rst_n = 1'b0;
      mif.flush = (k == 1);
      tick();
      check("rstmid.in_ready", 64'(mif.in_ready), 64'd0);
      check("rstmid.out_valid", 64'(mif.out_valid), 64'd0);
      check("rstmid.out_data", mif.out_data, 64'd0);
      check("rstmid.busy", 64'(mif.busy), 64'd0);
      rst_n = 1'b1;
      mif.flush = 1'b0;
      #1;
      run_op("rstmid.mul3x5", 3'd0, 1'b0, 64'd3, 64'd5, 64'd15);
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      wd = 1'($urandom_range(0, 1));
      a  = rnd_operand();
      b  = rnd_operand();
      run_op("rnd", op, wd, a, b, ref_md(op, wd, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
